// File: rtl/axil_counter_pkg.sv
// Shared definitions for the AXI4-Lite counter register block:
// register indices, response codes, FSM state types and the seven-segment lookup.
package axil_counter_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_SCRATCH  = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [1:0] value);
    logic [6:0] seg;
    case (value)
      2'd0:    seg = 7'b1000000;
      2'd1:    seg = 7'b1111001;
      2'd2:    seg = 7'b0100100;
      default: seg = 7'b0110000;
    endcase
    return seg;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_counter_regs_counter_core.sv
// Prescaled 2-bit counter with registered seven-segment decode.
module counter_core
  import axil_counter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] prescale,
  output logic [1:0]  count,
  output logic [6:0]  seg_n
);

  logic [31:0] pcnt;
  logic        tick;

  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      count <= '0;
      seg_n <= SEG_ZERO;
    end else begin
      seg_n <= seg_decode(count);
      if (clr) begin
        pcnt  <= '0;
        count <= '0;
      end else if (pcnt > prescale) begin
        // PRESCALE was lowered beneath the running count: restart the period
        pcnt <= '0;
      end else if (en) begin
        if (tick) begin
          pcnt  <= '0;
          count <= count + 2'd1;
        end else begin
          pcnt <= pcnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: rtl/axil_counter_regs.sv
// AXI4-Lite responder exposing CTRL/PRESCALE/SCRATCH/STATUS and driving the
// prescaled 2-bit counter and its seven-segment pins.
//
//   state  | meaning
//   W_IDLE | collecting AW and W independently; write fires once both are latched
//   W_RESP | BVALID high, waiting for BREADY
//   R_IDLE | ARREADY high, RDATA captured on the AR handshake
//   R_DATA | RVALID high, RDATA held until RREADY
module axil_counter_regs
  import axil_counter_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] PRESCALE_RST       = 32'd100_000_000
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [1:0]                        count,
  output logic [6:0]                        seg_n
);

  w_state_t    w_state, w_state_n;
  r_state_t    r_state, r_state_n;
  logic        ready_en;
  logic        aw_lat, w_lat;
  logic [1:0]  waddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        ctrl_en;
  logic [31:0] prescale_q, scratch_q;
  logic        wr_en, clr_pulse, aw_hs, w_hs, ar_hs;
  logic [31:0] rd_word;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Keeps every READY low in the cycle the bus leaves reset
  always_ff @(posedge ACLK) begin
    if (ARESET) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_n;
  end

  always_comb begin
    w_state_n = w_state;
    case (w_state)
      W_IDLE:  if (aw_lat && w_lat) w_state_n = W_RESP;
      W_RESP:  if (S_AXI_BREADY)    w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = ready_en && (w_state == W_IDLE) && !aw_lat;
    S_AXI_WREADY  = ready_en && (w_state == W_IDLE) && !w_lat;
    S_AXI_BVALID  = (w_state == W_RESP);
    S_AXI_BRESP   = RESP_OKAY;
    wr_en         = (w_state == W_IDLE) && aw_lat && w_lat;
  end

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_lat  <= 1'b0;
      w_lat   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if ((w_state == W_RESP) && S_AXI_BREADY) begin
      aw_lat <= 1'b0;
      w_lat  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_lat  <= 1'b1;
        waddr_q <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_lat   <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  assign clr_pulse = wr_en && (waddr_q == REG_CTRL) && wstrb_q[0] && wdata_q[1];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_en    <= 1'b0;
      prescale_q <= PRESCALE_RST;
      scratch_q  <= '0;
    end else if (wr_en) begin
      case (waddr_q)
        REG_CTRL:     if (wstrb_q[0]) ctrl_en <= wdata_q[0];
        REG_PRESCALE: prescale_q <= apply_strb(prescale_q, wdata_q, wstrb_q);
        REG_SCRATCH:  scratch_q  <= apply_strb(scratch_q, wdata_q, wstrb_q);
        default:      ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_n;
  end

  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)        r_state_n = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = ready_en && (r_state == R_IDLE);
    S_AXI_RVALID  = (r_state == R_DATA);
    S_AXI_RRESP   = RESP_OKAY;
    S_AXI_RDATA   = rdata_q;
  end

  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    rd_word = '0;
    case (S_AXI_ARADDR[3:2])
      REG_CTRL:     rd_word = {31'd0, ctrl_en};
      REG_PRESCALE: rd_word = prescale_q;
      REG_SCRATCH:  rd_word = scratch_q;
      default:      rd_word = {23'd0, seg_n, count};
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET)     rdata_q <= '0;
    else if (ar_hs) rdata_q <= rd_word;
  end

  counter_core u_core (
    .clk      (ACLK),
    .rst      (ARESET),
    .en       (ctrl_en),
    .clr      (clr_pulse),
    .prescale (prescale_q),
    .count    (count),
    .seg_n    (seg_n)
  );

endmodule
